// File: rtl/cpu_hazard_ctrl_if.sv
// rtl/cpu_hazard_ctrl_if.sv - pipeline hazard controller signal bundle
interface cpu_hazard_ctrl_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = $clog2(NUM_REGS)
);
    logic [REG_W-1:0] dec_reg_a;
    logic [REG_W-1:0] dec_reg_b;
    logic             dec_use_a;
    logic             dec_use_b;
    logic [REG_W-1:0] ex_reg_dest;
    logic             ex_write_back;
    logic             ex_is_load;
    logic             ex_div_start;
    logic             ex_branch_taken;
    logic             mem_miss;
    logic             mem_ready;
    logic             stall_fetch;
    logic             stall_decode;
    logic             stall_execute;
    logic             stall_commit;
    logic             flush_decode;
    logic             bubble_execute;
    logic             bubble_commit;
    logic             bubble_wb;
    logic             busy;
    logic [31:0]      stall_cycles;

    modport master (
        output dec_reg_a, dec_reg_b, dec_use_a, dec_use_b, ex_reg_dest,
               ex_write_back, ex_is_load, ex_div_start, ex_branch_taken,
               mem_miss, mem_ready,
        input  stall_fetch, stall_decode, stall_execute, stall_commit,
               flush_decode, bubble_execute, bubble_commit, bubble_wb,
               busy, stall_cycles
    );

    modport slave (
        input  dec_reg_a, dec_reg_b, dec_use_a, dec_use_b, ex_reg_dest,
               ex_write_back, ex_is_load, ex_div_start, ex_branch_taken,
               mem_miss, mem_ready,
        output stall_fetch, stall_decode, stall_execute, stall_commit,
               flush_decode, bubble_execute, bubble_commit, bubble_wb,
               busy, stall_cycles
    );
endinterface

// File: rtl/cpu_hazard_ctrl.sv
// rtl/cpu_hazard_ctrl.sv - load-use, branch, divide and miss stall/flush controller
module cpu_hazard_ctrl #(
    parameter int NUM_REGS    = 32,
    parameter int DIV_LATENCY = 8
) (
    input  logic               clk,
    input  logic               reset,
    cpu_hazard_ctrl_if.slave   hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        div_pending_q, div_pending_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // {stall_fetch, stall_decode, stall_execute, stall_commit,
    //  flush_decode, bubble_execute, bubble_commit, bubble_wb}
    localparam logic [7:0] CTRL_MISS = 8'b1111_0001;
    localparam logic [7:0] CTRL_DIV  = 8'b1110_0010;
    localparam logic [7:0] CTRL_BR   = 8'b0000_1100;
    localparam logic [7:0] CTRL_LU   = 8'b1100_0100;

    logic       lu;
    logic [7:0] ctrl;

    always_comb begin
        lu = hz.ex_is_load && hz.ex_write_back && (hz.ex_reg_dest != '0) &&
             ((hz.dec_use_a && (hz.dec_reg_a == hz.ex_reg_dest)) ||
              (hz.dec_use_b && (hz.dec_reg_b == hz.ex_reg_dest)));
    end

    always_comb begin
        state_d       = state_q;
        div_pending_d = div_pending_q;
        ctrl          = 8'b0;
        // The divider counts down regardless of state, so a miss overlaps it.
        cnt_d = (div_pending_q && (cnt_q != 8'd0)) ? cnt_q - 8'd1 : cnt_q;
        case (state_q)
            RUN: begin
                if (hz.mem_miss) begin
                    ctrl    = CTRL_MISS;
                    state_d = MEM_WAIT;
                end else if (hz.ex_div_start) begin
                    ctrl          = CTRL_DIV;
                    cnt_d         = 8'(DIV_LATENCY - 2);
                    div_pending_d = 1'b1;
                    state_d       = DIV_WAIT;
                end else if (hz.ex_branch_taken) begin
                    ctrl = CTRL_BR;
                end else if (lu) begin
                    ctrl = CTRL_LU;
                end
            end
            DIV_WAIT: begin
                if (hz.mem_miss) begin
                    ctrl    = CTRL_MISS;
                    state_d = MEM_WAIT;
                end else if (cnt_q != 8'd0) begin
                    ctrl = CTRL_DIV;
                end else begin
                    div_pending_d = 1'b0;
                    state_d       = RUN;
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    ctrl = CTRL_MISS;
                end else if (div_pending_q && (cnt_q != 8'd0)) begin
                    ctrl    = CTRL_DIV;
                    state_d = DIV_WAIT;
                end else begin
                    div_pending_d = 1'b0;
                    state_d       = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            ctrl = 8'b0;
        end
        stall_cycles_d = (ctrl[7] && (stall_cycles_q != 32'hFFFF_FFFF)) ?
                         stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= 8'd0;
            div_pending_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_pending_q  <= div_pending_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.stall_fetch    = ctrl[7];
    assign hz.stall_decode   = ctrl[6];
    assign hz.stall_execute  = ctrl[5];
    assign hz.stall_commit   = ctrl[4];
    assign hz.flush_decode   = ctrl[3];
    assign hz.bubble_execute = ctrl[2];
    assign hz.bubble_commit  = ctrl[1];
    assign hz.bubble_wb      = ctrl[0];
    assign hz.busy           = !reset && (state_q != RUN);
    assign hz.stall_cycles   = reset ? 32'd0 : stall_cycles_q;
endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// tb/tb_cpu_hazard_ctrl.sv - directed self-checking bench for cpu_hazard_ctrl
module tb_cpu_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cpu_hazard_ctrl_if #(.NUM_REGS(32)) bus ();

    cpu_hazard_ctrl #(.NUM_REGS(32), .DIV_LATENCY(8)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_MISS = 8'b1111_0001;
    localparam logic [7:0] C_DIV  = 8'b1110_0010;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_LU   = 8'b1100_0100;

    logic [7:0] ctrl;
    assign ctrl = {bus.stall_fetch, bus.stall_decode, bus.stall_execute, bus.stall_commit,
                   bus.flush_decode, bus.bubble_execute, bus.bubble_commit, bus.bubble_wb};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.dec_reg_a       = '0;
        bus.dec_reg_b       = '0;
        bus.dec_use_a       = 1'b0;
        bus.dec_use_b       = 1'b0;
        bus.ex_reg_dest     = '0;
        bus.ex_write_back   = 1'b0;
        bus.ex_is_load      = 1'b0;
        bus.ex_div_start    = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_miss        = 1'b0;
        bus.mem_ready       = 1'b0;
    endtask

    task automatic set_load_use();
        bus.ex_is_load    = 1'b1;
        bus.ex_write_back = 1'b1;
        bus.ex_reg_dest   = 5'd5;
        bus.dec_reg_b     = 5'd5;
        bus.dec_use_b     = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", ctrl, C_NONE);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_cnt", bus.stall_cycles, 32'd0);
        reset = 1'b0;

        cyc(); set_load_use(); #1;
        chk("lu_ctrl", ctrl, C_LU);
        cyc(); #1;
        chk("lu_release", ctrl, C_NONE);
        chk("lu_cnt", bus.stall_cycles, 32'd1);

        cyc(); set_load_use(); bus.ex_reg_dest = 5'd0; bus.dec_reg_b = 5'd0; #1;
        chk("lu_r0", ctrl, C_NONE);
        cyc(); set_load_use(); bus.dec_use_b = 1'b0; bus.dec_reg_a = 5'd5; #1;
        chk("lu_unused", ctrl, C_NONE);

        cyc(); set_load_use(); bus.ex_branch_taken = 1'b1; #1;
        chk("br_ctrl", ctrl, C_BR);
        cyc(); #1;
        chk("br_busy", bus.busy, 1'b0);
        chk("br_cnt", bus.stall_cycles, 32'd1);

        cyc(); bus.ex_div_start = 1'b1; #1;
        chk("div_c1", ctrl, C_DIV);
        chk("div_c1_busy", bus.busy, 1'b0);
        for (int i = 2; i <= 7; i++) begin
            cyc(); #1;
            chk("div_stall", ctrl, C_DIV);
            chk("div_busy", bus.busy, 1'b1);
        end
        cyc(); #1;
        chk("div_release", ctrl, C_NONE);
        cyc(); #1;
        chk("div_idle", bus.busy, 1'b0);
        chk("div_cnt", bus.stall_cycles, 32'd8);

        cyc(); bus.mem_miss = 1'b1; bus.ex_div_start = 1'b1; #1;
        chk("miss_t0", ctrl, C_MISS);
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            chk("miss_hold", ctrl, C_MISS);
            chk("miss_busy", bus.busy, 1'b1);
        end
        cyc(); bus.mem_ready = 1'b1; bus.ex_branch_taken = 1'b1; set_load_use(); #1;
        chk("miss_ready", ctrl, C_NONE);
        cyc(); #1;
        chk("miss_run", bus.busy, 1'b0);
        chk("miss_after", ctrl, C_NONE);
        chk("miss_cnt", bus.stall_cycles, 32'd13);

        cyc(); bus.ex_div_start = 1'b1; #1;
        chk("dm_c1", ctrl, C_DIV);
        cyc(); #1;
        chk("dm_c2", ctrl, C_DIV);
        cyc(); bus.mem_miss = 1'b1; #1;
        chk("dm_miss", ctrl, C_MISS);
        for (int i = 4; i <= 5; i++) begin
            cyc(); #1;
            chk("dm_hold", ctrl, C_MISS);
        end
        cyc(); bus.mem_ready = 1'b1; #1;
        chk("dm_resume", ctrl, C_DIV);
        cyc(); #1;
        chk("dm_c7", ctrl, C_DIV);
        chk("dm_c7_busy", bus.busy, 1'b1);
        cyc(); #1;
        chk("dm_release", ctrl, C_NONE);
        cyc(); #1;
        chk("dm_idle", bus.busy, 1'b0);
        chk("dm_cnt", bus.stall_cycles, 32'd20);

        cyc(); bus.ex_div_start = 1'b1; #1;
        chk("dl_c1", ctrl, C_DIV);
        cyc(); #1;
        cyc(); bus.mem_miss = 1'b1; #1;
        chk("dl_miss", ctrl, C_MISS);
        for (int i = 4; i <= 12; i++) begin
            cyc(); #1;
            chk("dl_hold", ctrl, C_MISS);
        end
        cyc(); bus.mem_ready = 1'b1; #1;
        chk("dl_release", ctrl, C_NONE);
        cyc(); #1;
        chk("dl_idle", bus.busy, 1'b0);
        chk("dl_cnt", bus.stall_cycles, 32'd32);

        cyc(); bus.mem_miss = 1'b1; #1;
        cyc(); #1;
        chk("rst_pre_busy", bus.busy, 1'b1);
        cyc(); reset = 1'b1; #1;
        chk("rst_ctrl", ctrl, C_NONE);
        chk("rst_cnt_in", bus.stall_cycles, 32'd0);
        cyc(); reset = 1'b0; #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_after_ctrl", ctrl, C_NONE);
        chk("rst_cnt", bus.stall_cycles, 32'd0);

        cyc(); bus.ex_div_start = 1'b1; #1;
        chk("sat_c1", ctrl, C_DIV);
        cyc(); force dut.stall_cycles_q = 32'hFFFF_FFFD;
        cyc(); release dut.stall_cycles_q;
        for (int i = 4; i <= 7; i++) cyc();
        #1;
        chk("sat_c7", ctrl, C_DIV);
        cyc(); #1;
        chk("sat_cnt", bus.stall_cycles, 32'hFFFF_FFFF);
        cyc(); bus.mem_miss = 1'b1; #1;
        cyc(); #1;
        chk("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
